// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// Holds the CPU program counter. The register loads PC_Next on a rising
// clock edge when PCWrite is high and holds its value otherwise. An
// asynchronous active-high reset forces it to RESET_PC at once, without
// waiting for a clock edge. PC_Plus is the sequential next address, formed
// combinationally from the register and wrapping modulo 2^PC_WIDTH.
//
// Parameters
//   PC_WIDTH  width of the program counter in bits
//   PC_STEP   sequential increment in bytes
//   RESET_PC  value loaded on reset (defaults to 2^PC_WIDTH - PC_STEP, so
//             the first sequential fetch after reset wraps round to 0)
//
// Ports
//   CPU_clk   in   1         clock; all state changes on its rising edge
//   CPU_rst   in   1         asynchronous active-high reset
//   PC_Next   in   PC_WIDTH  candidate next PC, loaded as-is (no alignment)
//   PCWrite   in   1         1 = load PC_Next, 0 = hold PC
//   PC        out  PC_WIDTH  current PC, driven straight from the register
//   PC_Plus   out  PC_WIDTH  PC + PC_STEP, truncated to PC_WIDTH bits
//   PC_Valid  out  1         PC has been loaded at least once since reset
// ---------------------------------------------------------------------------
module program_counter #(
    parameter int unsigned           PC_WIDTH = 32,
    parameter int unsigned           PC_STEP  = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(0) - PC_WIDTH'(PC_STEP)
) (
    input  logic                CPU_clk,
    input  logic                CPU_rst,
    input  logic [PC_WIDTH-1:0] PC_Next,
    input  logic                PCWrite,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PC_Plus,
    output logic                PC_Valid
);

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic                pc_valid_d;
    logic                pc_valid_q;

    // Next-state logic: load on PCWrite, otherwise hold.
    // NOTE: every signal gets its hold value before the if, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        if (PCWrite) begin
            pc_d       = PC_Next;
            pc_valid_d = 1'b1;
        end
    end

    // State register. Reset sits in the sensitivity list, so it wins over
    // PCWrite and takes effect between clock edges.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CPU_clk or posedge CPU_rst) begin
        if (CPU_rst) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign PC       = pc_q;
    assign PC_Valid = pc_valid_q;

    // The sum is kept at PC_WIDTH bits, so the carry out is dropped and the
    // result wraps through zero.
    assign PC_Plus  = pc_q + PC_WIDTH'(PC_STEP);

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//
// Directed sequence for the reset, load, hold, wrap and reset-priority cases,
// followed by random load/hold/reset traffic. Expected values come from a
// small model: a PC value and a valid bit updated by the load/hold/reset
// rules, with PC_Plus worked out in 64-bit arithmetic and reduced mod 2^32.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_program_counter;

    localparam int unsigned  W      = 32;
    localparam int unsigned  STEP   = 4;
    localparam logic [W-1:0] RST_PC = 32'hFFFF_FFFC;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [W-1:0] nxt;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus;
    logic         pc_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [W-1:0] m_pc;
    logic         m_valid;

    program_counter #(
        .PC_WIDTH (W),
        .PC_STEP  (STEP)
    ) dut (
        .CPU_clk  (clk),
        .CPU_rst  (rst),
        .PC_Next  (nxt),
        .PCWrite  (we),
        .PC       (pc),
        .PC_Plus  (pc_plus),
        .PC_Valid (pc_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] plus_of(input logic [W-1:0] p);
        longint s;
        s = longint'(p) + longint'(STEP);
        return W'(s % 64'sd4294967296);
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_pc"},    pc,                m_pc);
        check({tag, "_plus"},  pc_plus,           plus_of(m_pc));
        check({tag, "_valid"}, {31'b0, pc_valid}, {31'b0, m_valid});
    endtask

    // One rising edge: update the model from the inputs held across it,
    // then step off the edge so the outputs can be sampled.
    task automatic edge_step();
        @(posedge clk);
        if (rst) begin
            m_pc    = RST_PC;
            m_valid = 1'b0;
        end else if (we) begin
            m_pc    = nxt;
            m_valid = 1'b1;
        end
        #1;
    endtask

    // Raise reset between edges and check that it acts before any edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        m_pc    = RST_PC;
        m_valid = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        nxt = '0;
        #1;
        m_pc    = RST_PC;
        m_valid = 1'b0;
        check_all("reset");
        check("reset_pc_abs", pc, 32'hFFFF_FFFC);
        check("reset_plus_abs", pc_plus, 32'h0);

        edge_step();
        check_all("reset_edge");

        // First load after reset, then a hold with a different PC_Next.
        rst = 1'b0; nxt = '0; we = 1'b1;
        edge_step();
        check_all("load0");
        check("load0_abs", pc, 32'h0);
        nxt = 32'h4; we = 1'b0;
        edge_step();
        check_all("hold");
        check("hold_abs", pc, 32'h0);

        // Load 8, then three sequential steps.
        nxt = 32'h8; we = 1'b1;
        edge_step();
        check_all("load8");
        for (int i = 0; i < 3; i++) begin
            nxt = m_pc + 32'd4;
            edge_step();
            check_all("seq");
        end
        check("seq_end_abs", pc, 32'h14);

        // Reset mid-cycle with a load pending, then reset held with PCWrite.
        nxt = 32'h100; we = 1'b1;
        async_reset("mid_reset");
        edge_step();
        check_all("rst_prio");
        check("rst_prio_abs", pc, 32'hFFFF_FFFC);

        // Release; load the wrap value, then RESET_PC + STEP.
        rst = 1'b0; nxt = 32'hFFFF_FFFC; we = 1'b1;
        edge_step();
        check_all("wrap");
        check("wrap_plus_abs", pc_plus, 32'h0);
        nxt = RST_PC + 32'd4;
        edge_step();
        check_all("wrap_load");

        // Unaligned value is loaded unmodified.
        nxt = 32'h1234_5677;
        edge_step();
        check_all("unaligned");

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                async_reset("rnd_reset");
            end else if (rst && r < 10) begin
                rst = 1'b0;
            end
            we  = $urandom_range(0, 1) == 1;
            nxt = (r < 3) ? 32'hFFFF_FFFC : $urandom;
            edge_step();
            check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
